// File: rtl/mult_pkg.sv
// Shared constants and state type for the sequential shift-and-add multiplier.
package mult_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned COUNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

endpackage

// File: rtl/cla_adder.sv
// 32-bit carry-lookahead adder built from 4-bit lookahead groups chained by group G/P.
module cla_adder
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned GROUPS = WIDTH / 4;

    logic [WIDTH-1:0]  g;
    logic [WIDTH-1:0]  p;
    logic [WIDTH-1:0]  c;
    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_p;
    logic [GROUPS:0]   grp_c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        grp_g    = '0;
        grp_p    = '0;
        c        = '0;
        grp_c    = '0;
        grp_c[0] = cin;
        for (int j = 0; j < GROUPS; j++) begin
            grp_p[j] = &p[4*j +: 4];
            grp_g[j] = g[4*j+3]
                     | (p[4*j+3] & g[4*j+2])
                     | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
            // In-group carries expanded directly from the group carry-in.
            c[4*j]   = grp_c[j];
            c[4*j+1] = g[4*j] | (p[4*j] & grp_c[j]);
            c[4*j+2] = g[4*j+1]
                     | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & grp_c[j]);
            c[4*j+3] = g[4*j+2]
                     | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & grp_c[j]);
        end
    end

    assign sum  = p ^ c;
    assign cout = grp_c[GROUPS];

endmodule

// File: rtl/mult_sequencer.sv
// Shift-and-add multiplier sequencer time-sharing one cla_adder for the low WIDTH bits of A*B.
// Define MULT_EARLY_EXIT_EN to end RUN as soon as the remaining multiplier bits are zero.
module mult_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             data_result_ready,
    output logic             busy
);

    import mult_pkg::*;

    mult_state_t        state_q;
    mult_state_t        state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   acc_q;
    logic [COUNT_W-1:0] count_q;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               unused_cout;
    logic               last_add;

    assign addend = mplier_q[0] ? mcand_q : '0;

    cla_adder u_adder (
        .a    (acc_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (unused_cout)
    );

`ifdef MULT_EARLY_EXIT_EN
    // Stop once the multiplier left after this shift has no set bits.
    assign last_add = (&count_q) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign last_add = &count_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ctrl_mult) state_d = RUN;
            RUN:     if (last_add) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_result_ready = (state_q == DONE);
        busy              = (state_q != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (state_q == IDLE && ctrl_mult) begin
            mcand_q  <= operand_a;
            mplier_q <= operand_b;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (state_q == RUN) begin
            acc_q    <= sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + COUNT_W'(1);
        end
    end

    assign result = acc_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer against a product/latency model.
module tb_mult_sequencer;

    localparam int unsigned W = 32;
`ifdef MULT_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         ctrl_mult;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [W-1:0] result;
    logic         data_result_ready;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mult_sequencer #(.WIDTH(W)) dut (
        .clock             (clock),
        .reset             (reset),
        .ctrl_mult         (ctrl_mult),
        .operand_a         (operand_a),
        .operand_b         (operand_b),
        .result            (result),
        .data_result_ready (data_result_ready),
        .busy              (busy)
    );

    function automatic logic [W-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] full;
        full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return full[W-1:0];
    endfunction

    // Edges from the start edge to the edge that enters DONE.
    function automatic int model_latency(input logic [W-1:0] b);
        int hi;
        hi = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (b[i] && hi == 0) hi = i;
        end
        return EarlyExit ? hi + 1 : int'(W);
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        ctrl_mult = 1'b1;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1;
        ctrl_mult = 1'b0;
    endtask

    task automatic wait_ready(output int n, output bit seen);
        seen = 1'b0;
        n    = 0;
        for (int i = 1; i <= 40; i++) begin
            if (!seen) begin
                @(posedge clock);
                #1;
                if (data_result_ready) begin
                    seen = 1'b1;
                    n    = i;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        ctrl_mult = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (result !== '0 || data_result_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: result=%h ready=%b busy=%b, required 0/0/0",
                     result, data_result_ready, busy);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{32'd3, 32'hFFFF_FFFF, 32'h0001_0000, 32'd1234, 32'd1};
        logic [W-1:0] tb [5] = '{32'd5, 32'hFFFF_FFFF, 32'h0001_0000, 32'd0, 32'h8000_0000};
        logic [W-1:0] te [5] = '{32'd15, 32'd1, 32'd0, 32'd0, 32'h8000_0000};
        int  n;
        bit  seen;
        for (int t = 0; t < 5; t++) begin
            start_op(ta[t], tb[t]);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL directed%0d_busy_after_start: busy=%b, required 1", t, busy);
            end
            wait_ready(n, seen);
            checks++;
            if (!seen || n != model_latency(tb[t])) begin
                failures++;
                $display("FAIL directed%0d_latency: ready at E%0d (seen=%b), required E%0d",
                         t, n, seen, model_latency(tb[t]));
            end
            checks++;
            if (result !== te[t] || result !== model_product(ta[t], tb[t])) begin
                failures++;
                $display("FAIL directed%0d_result: result=%h, required %h", t, result, te[t]);
            end
            @(posedge clock);
            #1;
            checks++;
            if (data_result_ready !== 1'b0 || busy !== 1'b0 || result !== te[t]) begin
                failures++;
                $display("FAIL directed%0d_after_done: ready=%b busy=%b result=%h, required 0/0/%h",
                         t, data_result_ready, busy, result, te[t]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bit bad;
        start_op(32'd7, 32'd9);
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || result !== '0 || data_result_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_run_reset: busy=%b result=%h ready=%b, required 0/0/0",
                     busy, result, data_result_ready);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        bad   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_result_ready !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL mid_run_abandon: ready or busy rose after reset, required both 0");
        end
    endtask

    task automatic test_ignore_start();
        int  n;
        bit  seen;
        start_op(32'd100, 32'd200);
        repeat (4) @(posedge clock);
        #1;
        ctrl_mult = 1'b1;
        operand_a = 32'd11;
        operand_b = 32'd13;
        wait_ready(n, seen);
        checks++;
        if (!seen || n + 4 != model_latency(32'd200) || result !== 32'd20000) begin
            failures++;
            $display("FAIL ignore_first_op: ready at E%0d result=%h, required E%0d result=%h",
                     n + 4, result, model_latency(32'd200), 32'd20000);
        end
        @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || data_result_ready !== 1'b0 || result !== 32'd20000) begin
            failures++;
            $display("FAIL ignore_done_start: busy=%b ready=%b result=%h, required 0/0/%h",
                     busy, data_result_ready, result, 32'd20000);
        end
        @(posedge clock);
        #1;
        ctrl_mult = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ignore_accept_after_done: busy=%b, required 1", busy);
        end
        wait_ready(n, seen);
        checks++;
        if (!seen || n != model_latency(32'd13) || result !== 32'd143) begin
            failures++;
            $display("FAIL ignore_second_op: ready at E%0d result=%h, required E%0d result=%h",
                     n, result, model_latency(32'd13), 32'd143);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_back_to_back_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        int  n;
        bit  seen;
        for (int t = 0; t < 24; t++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            start_op(a, b);
            wait_ready(n, seen);
            checks++;
            if (!seen || n != model_latency(b) || result !== model_product(a, b)) begin
                failures++;
                $display("FAIL random%0d %h*%h: ready at E%0d result=%h, required E%0d result=%h",
                         t, a, b, n, result, model_latency(b), model_product(a, b));
            end
            @(posedge clock);
            #1;
            checks++;
            if (data_result_ready !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL random%0d_pulse_width: ready=%b busy=%b, required 0/0",
                         t, data_result_ready, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_run();
        test_ignore_start();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
